ps2_rx_frame: RTL
=================

# ps2_rx_frame

Receives PS/2 keyboard frames on ps2clk/ps2data and turns them into validated scan-code events for the main control FSM inside Proyect, which derives Temps, Gas, Alerta and Peligro from them. The block does four things:
- synchronises and filters the PS/2 lines;
- deframes the 11-bit frame (start bit, 8 data bits LSB first, odd parity, stop bit);
- folds the E0 (extended) and F0 (break) prefixes into flags on the following code;
- emits one-cycle event pulses.

## Interface
Parameters:
- FILTER_LEN, 8: CLK_G cycles ps2clk must hold a new level before it is accepted.
- TIMEOUT_CYC, 5000: CLK_G cycles without an accepted falling edge before an in-progress frame is aborted; 13-bit counter.

Ports:
- CLK_G, input, 1: system clock.
- reset_G, input, 1: asynchronous, active-low reset.
- ps2clk, input, 1: PS/2 clock line; asynchronous to CLK_G.
- ps2data, input, 1: PS/2 data line; asynchronous to CLK_G.
- Rx_en, input, 1: receive enable; edges are ignored while low.
- rx_data, output, 8: last accepted non-prefix scan code.
- rx_valid, output, 1: one-cycle pulse; rx_data, key_break and key_ext are valid in that cycle.
- key_break, output, 1: the code was preceded by F0.
- key_ext, output, 1: the code was preceded by E0.
- rx_err, output, 1: one-cycle pulse on a framing, parity or timeout error.

## Operation
- Line conditioning:
  - ps2clk and ps2data each pass through a 2-FF synchroniser.
  - The ps2clk filter changes its output only after FILTER_LEN consecutive equal samples.
  - An accepted falling edge of the filtered clock is `fall`; ps2data is sampled on `fall`.
- FSM states: IDLE, DATA, PARITY, STOP. bit_cnt is 3 bits; shift register is 8 bits, shifted in LSB first.
- IDLE:
  - `fall` with data=0 and Rx_en=1 → DATA, bit_cnt=0.
  - `fall` with data=1 → stay in IDLE, no error.
- DATA: each `fall` shifts one bit in; after the 8th bit → PARITY.
- PARITY: on `fall`, store the parity bit → STOP.
- STOP, on `fall`:
  - stop=1 and parity OK: the frame is accepted.
  - Otherwise: rx_err pulse, code discarded, both prefix flags cleared.
  - Either way → IDLE.
- Accepted frame handling:
  - Code 0xE0 sets ext_pend.
  - Code 0xF0 sets brk_pend.
  - Prefixes produce no rx_valid.
  - Any other code: rx_data ← code, key_ext ← ext_pend, key_break ← brk_pend, rx_valid pulse, then ext_pend and brk_pend are cleared.
- Timeout:
  - Runs only outside IDLE; cleared on each `fall`.
  - Reaching TIMEOUT_CYC → IDLE, rx_err pulse, prefix flags cleared.
- Rx_en low outside IDLE → IDLE immediately, no rx_err; prefix flags are kept.
- Reset values: rx_data=0x00, rx_valid=0, key_break=0, key_ext=0, rx_err=0, FSM=IDLE, all counters and flags 0.
- Reset asserted mid-frame discards the partial frame; the first full frame after release is received normally.

## Timing
- Input latency: 2 synchroniser cycles + FILTER_LEN cycles from a pin edge to `fall`.
- rx_valid and rx_err assert in the CLK_G cycle after the `fall` that sampled the stop bit; each is high for exactly 1 cycle.
- rx_data, key_break and key_ext hold their values until the next rx_valid.
- rx_valid and rx_err are never high in the same cycle.
- A timeout and a `fall` in the same cycle: `fall` wins and the timeout counter is cleared.
- Back-to-back frames need no idle gap beyond the stop bit.

## Configuration
- PS2_PARITY_CHECK_EN defined: odd parity is checked over the 8 data bits plus the parity bit; a mismatch gives rx_err and the code is discarded.
- PS2_PARITY_CHECK_EN undefined: the parity bit is sampled and ignored, so only the start and stop bits are checked.

## Structure
- Package ps2_pkg contains:
  - state enum: IDLE, DATA, PARITY, STOP;
  - constants PS2_CODE_EXT=8'hE0 and PS2_CODE_BRK=8'hF0;
  - frame length constant 11.
- Sub-module ps2_sync_filter (parameter FILTER_LEN): 2-FF synchronisers for both lines, glitch filter, and outputs fall_o and data_o.
- Top level contains the FSM, shift register, prefix flags and timeout counter.

## Test plan
- Valid frame 0x1C (data LSB first, parity bit 0, stop 1) → rx_valid for 1 cycle, rx_data=0x1C, key_break=0, key_ext=0.
- Frames F0 then 1C → exactly one rx_valid: rx_data=0x1C, key_break=1, key_ext=0; a following bare 1C → key_break=0.
- Frames E0, F0, 75 → one rx_valid: rx_data=0x75, key_ext=1, key_break=1.
- Frame 0x1C with the parity bit forced to 1, PS2_PARITY_CHECK_EN defined → rx_err pulse, no rx_valid. Without the macro → rx_valid with rx_data=0x1C.
- Frame 0x29 stopped after 5 data bits, ps2clk idle for more than 5000 cycles → rx_err pulse. The next full 0x29 frame → rx_valid with rx_data=0x29.
- reset_G driven low during bit 4 of a frame → all outputs 0 and FSM=IDLE. After release, frame 0x1C → rx_valid with rx_data=0x1C.

Source files
------------

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver:
//   - ps2_state_t     : receiver FSM states (IDLE, DATA, PARITY, STOP)
//   - PS2_CODE_EXT    : extended-key prefix code (E0)
//   - PS2_CODE_BRK    : break (key release) prefix code (F0)
//   - PS2_FRAME_LEN   : bits per PS/2 frame (start + 8 data + parity + stop)
//   - ps2_odd_parity_ok : odd-parity check over data bits plus parity bit
// ----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_CODE_EXT  = 8'hE0;
    localparam logic [7:0] PS2_CODE_BRK  = 8'hF0;
    localparam int         PS2_FRAME_LEN = 11;

    // PS/2 uses odd parity: the 8 data bits plus the parity bit carry an odd
    // number of ones.
    function automatic logic ps2_odd_parity_ok(input logic [7:0] data,
                                               input logic       par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// ----------------------------------------------------------------------------
// ps2_sync_filter
// Brings the asynchronous PS/2 lines into the CLK_G domain and cleans up the
// clock line.
//   - Two-flop synchroniser on both ps2clk and ps2data (idle level 1).
//   - Glitch filter on ps2clk: the filtered level follows the synchronised
//     level only after FILTER_LEN consecutive samples that differ from it.
//   - fall_o : one-cycle pulse when the filtered clock goes 1 -> 0.
//   - data_o : synchronised ps2data, to be sampled when fall_o is high.
// Ports:
//   CLK_G      in   system clock
//   reset_G    in   asynchronous active-low reset
//   i_ps2clk   in   raw PS/2 clock line
//   i_ps2data  in   raw PS/2 data line
//   fall_o     out  accepted falling edge of the filtered clock (pulse)
//   data_o     out  synchronised data line
// ----------------------------------------------------------------------------
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic CLK_G,
    input  logic reset_G,
    input  logic i_ps2clk,
    input  logic i_ps2data,
    output logic fall_o,
    output logic data_o
);

    localparam int             CW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_LEN - 1);

    logic          r_clk_s1;
    logic          r_clk_s2;
    logic          r_data_s1;
    logic          r_data_s2;
    logic          r_clk_filt;
    logic [CW-1:0] r_filt_cnt;
    logic          r_fall;

    // Two-flop synchronisers; lines reset to their idle-high level.
    always_ff @(posedge CLK_G or negedge reset_G) begin
        if (!reset_G) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
        end else begin
            r_clk_s1  <= i_ps2clk;
            r_clk_s2  <= r_clk_s1;
            r_data_s1 <= i_ps2data;
            r_data_s2 <= r_data_s1;
        end
    end

    // Clock glitch filter: any sample equal to the current filtered level
    // restarts the run, so only an uninterrupted run of FILTER_LEN new-level
    // samples flips the output.
    always_ff @(posedge CLK_G or negedge reset_G) begin
        if (!reset_G) begin
            r_clk_filt <= 1'b1;
            r_filt_cnt <= {CW{1'b0}};
            r_fall     <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clk_s2 != r_clk_filt) begin
                if (r_filt_cnt == CNT_MAX) begin
                    r_clk_filt <= r_clk_s2;
                    r_filt_cnt <= {CW{1'b0}};
                    r_fall     <= ~r_clk_s2;
                end else begin
                    r_filt_cnt <= r_filt_cnt + CW'(1);
                end
            end else begin
                r_filt_cnt <= {CW{1'b0}};
            end
        end
    end

    assign fall_o = r_fall;
    assign data_o = r_data_s2;

endmodule

// File: rtl/ps2_rx_frame.sv
// ----------------------------------------------------------------------------
// ps2_rx_frame
// PS/2 keyboard frame receiver. Deframes 11-bit frames (start 0, 8 data bits
// LSB first, odd parity, stop 1), folds E0/F0 prefixes into flags on the
// next code and emits one-cycle scan-code events.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd
// parity; otherwise the parity bit is ignored and only start/stop are checked.
// Parameters:
//   FILTER_LEN  : cycles ps2clk must hold a new level before it is accepted
//   TIMEOUT_CYC : cycles without a falling edge before a frame is aborted
// Ports:
//   CLK_G      in   system clock
//   reset_G    in   asynchronous active-low reset
//   ps2clk     in   PS/2 clock line (asynchronous)
//   ps2data    in   PS/2 data line (asynchronous)
//   Rx_en      in   receive enable
//   rx_data    out  last accepted non-prefix scan code
//   rx_valid   out  one-cycle pulse, rx_data/key_break/key_ext valid
//   key_break  out  code was preceded by F0
//   key_ext    out  code was preceded by E0
//   rx_err     out  one-cycle pulse on framing, parity or timeout error
// ----------------------------------------------------------------------------
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       CLK_G,
    input  logic       reset_G,
    input  logic       ps2clk,
    input  logic       ps2data,
    input  logic       Rx_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       key_break,
    output logic       key_ext,
    output logic       rx_err
);

    localparam logic [12:0] TO_MAX = 13'(TIMEOUT_CYC - 1);

    logic        w_fall;
    logic        w_data;
    logic        w_par_ok;

    ps2_state_t  r_state;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [12:0] r_to_cnt;
    logic        r_ext_pend;
    logic        r_brk_pend;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_key_break;
    logic        r_key_ext;
    logic        r_rx_err;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync_filter (
        .CLK_G     (CLK_G),
        .reset_G   (reset_G),
        .i_ps2clk  (ps2clk),
        .i_ps2data (ps2data),
        .fall_o    (w_fall),
        .data_o    (w_data)
    );

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity;

    // Parity bit captured in the PARITY state, checked when the stop bit lands.
    always_ff @(posedge CLK_G or negedge reset_G) begin
        if (!reset_G) begin
            r_parity <= 1'b0;
        end else if (w_fall && (r_state == PARITY)) begin
            r_parity <= w_data;
        end else begin
            r_parity <= r_parity;
        end
    end

    assign w_par_ok = ps2_odd_parity_ok(r_shift, r_parity);
`else
    assign w_par_ok = 1'b1;
`endif

    // Frame FSM, shift register, prefix flags, timeout and event outputs.
    always_ff @(posedge CLK_G or negedge reset_G) begin
        if (!reset_G) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_to_cnt    <= 13'd0;
            r_ext_pend  <= 1'b0;
            r_brk_pend  <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_key_break <= 1'b0;
            r_key_ext   <= 1'b0;
            r_rx_err    <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_to_cnt <= 13'd0;
                    // A high data bit on a fall is line noise, not a start bit.
                    if (w_fall && Rx_en && !w_data) begin
                        r_state   <= DATA;
                        r_bit_cnt <= 3'd0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    if (!Rx_en) begin
                        // Silent abort; pending prefixes survive the disable.
                        r_state  <= IDLE;
                        r_to_cnt <= 13'd0;
                    end else if (w_fall) begin
                        // A fall always beats a simultaneous timeout.
                        r_to_cnt <= 13'd0;
                        case (r_state)
                            DATA: begin
                                r_shift <= {w_data, r_shift[7:1]};
                                if (r_bit_cnt == 3'd7) begin
                                    r_state <= PARITY;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 3'd1;
                                end
                            end
                            PARITY: begin
                                r_state <= STOP;
                            end
                            STOP: begin
                                r_state <= IDLE;
                                if (w_data && w_par_ok) begin
                                    if (r_shift == PS2_CODE_EXT) begin
                                        r_ext_pend <= 1'b1;
                                    end else if (r_shift == PS2_CODE_BRK) begin
                                        r_brk_pend <= 1'b1;
                                    end else begin
                                        r_rx_data   <= r_shift;
                                        r_key_ext   <= r_ext_pend;
                                        r_key_break <= r_brk_pend;
                                        r_rx_valid  <= 1'b1;
                                        r_ext_pend  <= 1'b0;
                                        r_brk_pend  <= 1'b0;
                                    end
                                end else begin
                                    r_rx_err   <= 1'b1;
                                    r_ext_pend <= 1'b0;
                                    r_brk_pend <= 1'b0;
                                end
                            end
                            default: begin
                                r_state <= IDLE;
                            end
                        endcase
                    end else if (r_to_cnt == TO_MAX) begin
                        r_state    <= IDLE;
                        r_to_cnt   <= 13'd0;
                        r_rx_err   <= 1'b1;
                        r_ext_pend <= 1'b0;
                        r_brk_pend <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 13'd1;
                    end
                end
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign key_break = r_key_break;
    assign key_ext   = r_key_ext;
    assign rx_err    = r_rx_err;

endmodule
